// File: rtl/dbf_beam_sum_if.sv
// Beam-combiner port bundle: per-channel weighted I/Q in, framed beam sample stream out.
// Streaming is valid-only: a sample transfers on every cycle its valid is 1; there is no ready/backpressure.
interface dbf_beam_sum_if #(
    parameter int NCH   = 8,
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
);
    logic [NCH*IN_W-1:0]     din_i;
    logic [NCH*IN_W-1:0]     din_q;
    logic                    din_valid;
    logic                    frame_start;
    logic [NCH-1:0]          ch_mask;
    logic                    clr_sat;
    logic signed [OUT_W-1:0] dout_i;
    logic signed [OUT_W-1:0] dout_q;
    logic                    dout_valid;
    logic                    dout_last;
    logic                    sat_flag;

    modport master (
        output din_i, din_q, din_valid, frame_start, ch_mask, clr_sat,
        input  dout_i, dout_q, dout_valid, dout_last, sat_flag
    );

    modport slave (
        input  din_i, din_q, din_valid, frame_start, ch_mask, clr_sat,
        output dout_i, dout_q, dout_valid, dout_last, sat_flag
    );
endinterface

// File: rtl/dbf_beam_sum.sv
// Beam combiner: masked input register, pipelined adder tree, shift + saturate, frame counter.
// Optional build macro DBF_SUM_ROUND_EN selects round-half-up before the shift instead of truncation.
module dbf_beam_sum #(
    parameter int NCH       = 8,
    parameter int IN_W      = 32,
    parameter int OUT_W     = 16,
    parameter int SHIFT     = 16,
    parameter int FRAME_LEN = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    dbf_beam_sum_if.slave    bus
);
    localparam int LV = $clog2(NCH);
    localparam int SW = IN_W + LV;
    localparam int RW = SW + 1;
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic signed [RW-1:0] SAT_MAX = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;
`ifdef DBF_SUM_ROUND_EN
    localparam logic signed [RW-1:0] HALF = RW'(64'sd1 <<< (SHIFT - 1));
`endif

    // Valid and frame-start tags ride one bit per pipeline level alongside the data.
    logic [LV:0] vld_sr;
    logic [LV:0] fs_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
            fs_sr  <= '0;
        end else begin
            vld_sr <= {vld_sr[LV-1:0], bus.din_valid};
            fs_sr  <= {fs_sr[LV-1:0], bus.din_valid & bus.frame_start};
        end
    end

    for (genvar l = 0; l <= LV; l++) begin : g_lvl
        localparam int N = NCH >> l;
        localparam int W = IN_W + l;
        logic signed [W-1:0] acc_i [N];
        logic signed [W-1:0] acc_q [N];

        if (l == 0) begin : g_in
            // Mask is applied in the same register as the sample, so it can change per sample.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < N; k++) begin
                        acc_i[k] <= '0;
                        acc_q[k] <= '0;
                    end
                end else begin
                    for (int k = 0; k < N; k++) begin
                        acc_i[k] <= bus.ch_mask[k] ? bus.din_i[k*IN_W +: IN_W] : '0;
                        acc_q[k] <= bus.ch_mask[k] ? bus.din_q[k*IN_W +: IN_W] : '0;
                    end
                end
            end
        end else begin : g_add
            // One extra bit per level makes overflow inside the tree impossible.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < N; k++) begin
                        acc_i[k] <= '0;
                        acc_q[k] <= '0;
                    end
                end else begin
                    for (int k = 0; k < N; k++) begin
                        acc_i[k] <= W'(g_lvl[l-1].acc_i[2*k]) + W'(g_lvl[l-1].acc_i[2*k+1]);
                        acc_q[k] <= W'(g_lvl[l-1].acc_q[2*k]) + W'(g_lvl[l-1].acc_q[2*k+1]);
                    end
                end
            end
        end
    end

    logic signed [SW-1:0] sum_i;
    logic signed [SW-1:0] sum_q;
    assign sum_i = g_lvl[LV].acc_i[0];
    assign sum_q = g_lvl[LV].acc_q[0];

    // Returns {saturated, value}.
    function automatic logic [OUT_W:0] scale_sat(input logic signed [SW-1:0] sum);
        logic signed [RW-1:0] ext;
        logic signed [RW-1:0] sh;
        ext = RW'(sum);
`ifdef DBF_SUM_ROUND_EN
        ext = ext + HALF;
`endif
        sh = ext >>> SHIFT;
        if (sh > SAT_MAX)      scale_sat = {1'b1, SAT_MAX[OUT_W-1:0]};
        else if (sh < SAT_MIN) scale_sat = {1'b1, SAT_MIN[OUT_W-1:0]};
        else                   scale_sat = {1'b0, sh[OUT_W-1:0]};
    endfunction

    logic [OUT_W:0] res_i;
    logic [OUT_W:0] res_q;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;
    logic [CW-1:0]  cnt_nxt;
    logic           last_nxt;

    always_comb begin
        res_i    = scale_sat(sum_i);
        res_q    = scale_sat(sum_q);
        cnt_inc  = fs_sr[LV] ? CW'(1) : cnt + CW'(1);
        last_nxt = vld_sr[LV] && (cnt_inc == CW'(FRAME_LEN));
        cnt_nxt  = cnt;
        if (vld_sr[LV]) cnt_nxt = last_nxt ? '0 : cnt_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout_i     <= '0;
            bus.dout_q     <= '0;
            bus.dout_valid <= 1'b0;
            bus.dout_last  <= 1'b0;
            bus.sat_flag   <= 1'b0;
            cnt            <= '0;
        end else begin
            bus.dout_valid <= vld_sr[LV];
            bus.dout_last  <= last_nxt;
            cnt            <= cnt_nxt;
            if (vld_sr[LV]) begin
                bus.dout_i <= res_i[OUT_W-1:0];
                bus.dout_q <= res_q[OUT_W-1:0];
            end
            // A saturating output beats a simultaneous clear.
            if (vld_sr[LV] && (res_i[OUT_W] || res_q[OUT_W])) bus.sat_flag <= 1'b1;
            else if (bus.clr_sat)                               bus.sat_flag <= 1'b0;
        end
    end
endmodule
